// File: rtl/gpio_mon_pkg.sv
// Shared types and the per-slice signature compare for the GPIO signature monitor.
package gpio_mon_pkg;

    // Widest channel slice the shared compare function accepts.
    localparam int unsigned SIG_MAX_W = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } mon_state_e;

    // Masked compare of one channel slice; narrower slices are zero-extended by the caller,
    // and zero mask bits in the padding compare as don't-care.
    function automatic logic slice_match(
        input logic [SIG_MAX_W-1:0] val,
        input logic [SIG_MAX_W-1:0] oe,
        input logic [SIG_MAX_W-1:0] sig,
        input logic [SIG_MAX_W-1:0] mask,
        input logic                 req_oe
    );
        logic val_ok;
        logic oe_ok;
        val_ok = (((val ^ sig) & mask) == '0);
        oe_ok  = ((oe | ~mask) == '1);
        return val_ok && (!req_oe || oe_ok);
    endfunction

endpackage

// File: rtl/gpio_sig_match.sv
// Single-channel masked signature compare (combinational).
module gpio_sig_match
    import gpio_mon_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter int unsigned REQ_OE = 0
) (
    input  logic [W-1:0] val,
    input  logic [W-1:0] oe,
    input  logic [W-1:0] sig,
    input  logic [W-1:0] mask,
    output logic         hit_c
);

    // Channel matches when every masked bit agrees (and is driven, if OE is required).
    always_comb begin
        hit_c = slice_match(SIG_MAX_W'(val), SIG_MAX_W'(oe), SIG_MAX_W'(sig),
                            SIG_MAX_W'(mask), (REQ_OE != 0));
    end

endmodule

// File: rtl/gpio_sig_monitor.sv
// Watches GPIO outputs for a pass or fail signature after an arm pulse and
// reports a sticky pass / fail / timeout verdict.
module gpio_sig_monitor
    import gpio_mon_pkg::*;
#(
    parameter int unsigned NCH    = 3,
    parameter int unsigned W      = 32,
    parameter int unsigned HOLD   = 10,
    parameter int unsigned TMO_W  = 32,
    parameter int unsigned REQ_OE = 0
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               start,
    input  logic [TMO_W-1:0]   tmo_limit,
    input  logic [NCH*W-1:0]   pass_sig,
    input  logic [NCH*W-1:0]   fail_sig,
    input  logic [NCH*W-1:0]   sig_mask,
    input  logic [NCH*W-1:0]   gpio_out,
    input  logic [NCH*W-1:0]   gpio_oe,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic               timeout,
    output logic [TMO_W-1:0]   cycles,
    output logic [NCH-1:0]     match_vec
);

    localparam int unsigned HOLD_W = $clog2(HOLD + 1);

    logic [NCH-1:0]    pass_vec_c;
    logic [NCH-1:0]    fail_vec_c;
    logic              pass_hit_q;
    logic              fail_hit_q;

    mon_state_e        state_q;
    mon_state_e        state_d;
    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;
    logic [HOLD_W-1:0] cnt_inc;
    logic [TMO_W-1:0]  cycles_d;
    logic              pass_d;
    logic              fail_d;
    logic              tmo_d;
    logic              tmo_hit;
    logic              finish;

    // Per-channel pass and fail comparators.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        gpio_sig_match #(.W(W), .REQ_OE(REQ_OE)) u_pass (
            .val   (gpio_out[c*W +: W]),
            .oe    (gpio_oe[c*W +: W]),
            .sig   (pass_sig[c*W +: W]),
            .mask  (sig_mask[c*W +: W]),
            .hit_c (pass_vec_c[c])
        );
        gpio_sig_match #(.W(W), .REQ_OE(REQ_OE)) u_fail (
            .val   (gpio_out[c*W +: W]),
            .oe    (gpio_oe[c*W +: W]),
            .sig   (fail_sig[c*W +: W]),
            .mask  (sig_mask[c*W +: W]),
            .hit_c (fail_vec_c[c])
        );
    end

    // Register the all-channel hits; the FSM only ever looks at these.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pass_hit_q <= 1'b0;
            fail_hit_q <= 1'b0;
            match_vec  <= '0;
        end else begin
            pass_hit_q <= &pass_vec_c;
            fail_hit_q <= &fail_vec_c;
            match_vec  <= pass_vec_c;
        end
    end

    // Timeout fires on the last permitted cycle; a zero limit disables it.
    always_comb begin
        tmo_hit = (tmo_limit != '0) && (cycles == (tmo_limit - TMO_W'(1)));
    end

    // Next state, hold count, cycle count and verdict; start > fail > pass > timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cycles_d = cycles;
        pass_d   = pass;
        fail_d   = fail;
        tmo_d    = timeout;
        finish   = 1'b0;
        cnt_inc  = cnt_q + HOLD_W'(1);
        if (start) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            cycles_d = '0;
            pass_d   = 1'b0;
            fail_d   = 1'b0;
            tmo_d    = 1'b0;
        end else if ((state_q == ST_RUN) || (state_q == ST_HOLD)) begin
            if (fail_hit_q) begin
                state_d = ST_DONE;
                fail_d  = 1'b1;
                finish  = 1'b1;
            end else if (pass_hit_q) begin
                if (cnt_inc == HOLD_W'(HOLD)) begin
                    state_d = ST_DONE;
                    pass_d  = 1'b1;
                    finish  = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = cnt_inc;
                end
            end else begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            if (!finish && tmo_hit) begin
                state_d = ST_DONE;
                tmo_d   = 1'b1;
                finish  = 1'b1;
            end
            if (!finish && (cycles != '1)) begin
                cycles_d = cycles + TMO_W'(1);
            end
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cycles  <= '0;
            pass    <= 1'b0;
            fail    <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cycles  <= cycles_d;
            pass    <= pass_d;
            fail    <= fail_d;
            timeout <= tmo_d;
            busy    <= (state_d == ST_RUN) || (state_d == ST_HOLD);
            done    <= (state_d == ST_DONE);
        end
    end

endmodule

// File: tb/tb_gpio_sig_monitor.sv
// Bench for gpio_sig_monitor: a default instance and an OE-qualified, short-counter
// instance share stimulus and are checked each cycle against a behavioural model.
module tb_gpio_sig_monitor;

    localparam int unsigned NCH = 3;
    localparam int unsigned W   = 32;
    localparam int unsigned SW  = NCH * W;

    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_RUN  = 2'd1;
    localparam logic [1:0] P_HOLD = 2'd2;
    localparam logic [1:0] P_DONE = 2'd3;

    localparam logic [SW-1:0] PS   = 96'hF00FE00C_F00FE00D_F00FE00E;
    localparam logic [SW-1:0] FS   = 96'hDEAD0000_DEAD0001_DEAD0002;
    localparam logic [SW-1:0] IDLE = 96'h12345678_9ABCDEF0_0BADC0DE;

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic            start;
    logic [31:0]     tmo_limit;
    logic [SW-1:0]   pass_sig, fail_sig, sig_mask, gpio_out, gpio_oe;

    logic            d_busy, d_done, d_pass, d_fail, d_timeout;
    logic [31:0]     d_cycles;
    logic [NCH-1:0]  d_mv;
    logic            o_busy, o_done, o_pass, o_fail, o_timeout;
    logic [7:0]      o_cycles;
    logic [NCH-1:0]  o_mv;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [1:0]     phase;
        logic [31:0]    cnt;
        logic [63:0]    cyc;
        logic           p;
        logic           f;
        logic           t;
        logic           ph;
        logic           fh;
        logic [NCH-1:0] mv;
    } model_t;

    model_t md, mo;

    gpio_sig_monitor u_def (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .tmo_limit(tmo_limit),
        .pass_sig(pass_sig), .fail_sig(fail_sig), .sig_mask(sig_mask),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe),
        .busy(d_busy), .done(d_done), .pass(d_pass), .fail(d_fail),
        .timeout(d_timeout), .cycles(d_cycles), .match_vec(d_mv)
    );

    gpio_sig_monitor #(.NCH(3), .W(32), .HOLD(3), .TMO_W(8), .REQ_OE(1)) u_oe (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .tmo_limit(tmo_limit[7:0]),
        .pass_sig(pass_sig), .fail_sig(fail_sig), .sig_mask(sig_mask),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe),
        .busy(o_busy), .done(o_done), .pass(o_pass), .fail(o_fail),
        .timeout(o_timeout), .cycles(o_cycles), .match_vec(o_mv)
    );

    always #5 HCLK = ~HCLK;

    // Which channels currently satisfy a signature.
    function automatic logic [NCH-1:0] hits(input logic [SW-1:0] sig, input bit oe_req);
        logic [NCH-1:0] r;
        logic [W-1:0]   g, s, m, e;
        for (int c = 0; c < NCH; c++) begin
            g = gpio_out[c*W +: W];
            s = sig[c*W +: W];
            m = sig_mask[c*W +: W];
            e = gpio_oe[c*W +: W];
            r[c] = (((g ^ s) & m) == '0) && (!oe_req || ((e | ~m) == {W{1'b1}}));
        end
        return r;
    endfunction

    // One clock of the monitor as the rules describe it.
    function automatic model_t step(input model_t m, input int hold, input int tw, input bit oe_req);
        model_t         n;
        logic [63:0]    cmax;
        logic [63:0]    lim;
        logic [NCH-1:0] pv, fv;
        bit             fin;
        n    = m;
        cmax = (64'd1 << tw) - 64'd1;
        lim  = 64'(tmo_limit) & cmax;
        pv   = hits(pass_sig, oe_req);
        fv   = hits(fail_sig, oe_req);
        n.ph = &pv;
        n.fh = &fv;
        n.mv = pv;
        fin  = 1'b0;
        if (start) begin
            n.phase = P_RUN; n.cnt = 0; n.cyc = 0; n.p = 0; n.f = 0; n.t = 0;
        end else if (m.phase == P_RUN || m.phase == P_HOLD) begin
            if (m.fh) begin
                n.phase = P_DONE; n.f = 1'b1; fin = 1'b1;
            end else if (m.ph) begin
                n.cnt = m.cnt + 32'd1;
                if (int'(n.cnt) >= hold) begin
                    n.phase = P_DONE; n.p = 1'b1; fin = 1'b1;
                end else begin
                    n.phase = P_HOLD;
                end
            end else begin
                n.phase = P_RUN; n.cnt = 0;
            end
            if (!fin && lim != 0 && m.cyc == lim - 64'd1) begin
                n.phase = P_DONE; n.t = 1'b1; fin = 1'b1;
            end
            if (!fin) n.cyc = (m.cyc == cmax) ? cmax : m.cyc + 64'd1;
        end
        return n;
    endfunction

    function automatic logic [71:0] mpack(input model_t m);
        return {(m.phase == P_RUN) || (m.phase == P_HOLD), m.phase == P_DONE,
                m.p, m.f, m.t, m.mv, m.cyc};
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model advances on the same edges as the DUTs.
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            md <= '0;
            mo <= '0;
        end else begin
            md <= step(md, 10, 32, 1'b0);
            mo <= step(mo, 3, 8, 1'b1);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge HCLK) begin
        if (chk_en) begin
            chk("cyc_def", {d_busy, d_done, d_pass, d_fail, d_timeout, d_mv, 64'(d_cycles)}, mpack(md));
            chk("cyc_oe",  {o_busy, o_done, o_pass, o_fail, o_timeout, o_mv, 64'(o_cycles)}, mpack(mo));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic pulse_start();
        @(negedge HCLK);
        start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
    endtask

    // Edges from now until each instance first reports done (0 = not within bound).
    task automatic measure(output int nd, output int no);
        nd = 0;
        no = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge HCLK);
            if (d_done && nd == 0) nd = i;
            if (o_done && no == 0) no = i;
        end
    endtask

    int nd, no;

    initial begin
        HRESETn   = 1'b0;
        start     = 1'b0;
        tmo_limit = 32'd1000;
        pass_sig  = PS;
        fail_sig  = FS;
        sig_mask  = '1;
        gpio_out  = IDLE;
        gpio_oe   = '1;
        tick(3);
        chk("reset_def", {d_busy, d_done, d_pass, d_fail, d_timeout, d_mv, 64'(d_cycles)}, 72'd0);
        chk("reset_oe",  {o_busy, o_done, o_pass, o_fail, o_timeout, o_mv, 64'(o_cycles)}, 72'd0);
        HRESETn = 1'b1;
        chk_en  = 1'b1;

        // Match held until pass.
        pulse_start();
        gpio_out = PS;
        measure(nd, no);
        chk("pass_latency_def", 72'(nd), 72'd11);
        chk("pass_latency_oe",  72'(no), 72'd4);
        chk("pass_flags_def", {69'd0, d_pass, d_fail, d_timeout}, 72'b100);
        chk("pass_cycles_def", 72'(d_cycles), 72'd10);
        chk("pass_cycles_oe",  72'(o_cycles), 72'd3);
        gpio_out = FS;
        tick(5);
        chk("done_frozen_def", {69'd0, d_pass, d_fail, d_timeout}, 72'b100);

        // Hold broken after 5 cycles, then re-established.
        gpio_out = IDLE;
        pulse_start();
        gpio_out = PS;
        tick(5);
        gpio_out = IDLE;
        tick(1);
        gpio_out = PS;
        tick(1);
        chk("hold_drop_busy_def", {70'd0, d_busy, d_done}, 72'b10);
        gpio_out = PS;
        measure(nd, no);
        chk("rehold_latency_def", 72'(nd + 1), 72'd11);

        // Pass and fail both matching: fail wins.
        gpio_out = IDLE;
        pulse_start();
        fail_sig = PS;
        gpio_out = PS;
        tick(4);
        chk("both_def", {69'd0, d_pass, d_fail, d_timeout}, 72'b010);
        chk("both_oe",  {69'd0, o_pass, o_fail, o_timeout}, 72'b010);
        fail_sig = FS;

        // Timeout at the limit.
        gpio_out  = IDLE;
        tmo_limit = 32'd50;
        pulse_start();
        tick(49);
        chk("tmo_not_yet_def", {71'd0, d_done}, 72'd0);
        tick(1);
        chk("tmo_def", {69'd0, d_pass, d_fail, d_timeout}, 72'b001);
        chk("tmo_cycles_def", 72'(d_cycles), 72'd49);
        chk("tmo_cycles_oe",  72'(o_cycles), 72'd49);

        // Timeout disabled; short counter saturates.
        tmo_limit = 32'd0;
        pulse_start();
        tick(2000);
        chk("no_tmo_def", {70'd0, d_busy, d_done}, 72'b10);
        chk("no_tmo_cycles_def", 72'(d_cycles), 72'd2000);
        chk("sat_cycles_oe", 72'(o_cycles), 72'd255);

        // Output-enable qualification on a single masked bit.
        tmo_limit = 32'd1000;
        gpio_out  = PS;
        gpio_oe   = ~96'h1;
        tick(2);
        chk("oe_low_oe",  72'(o_mv), 72'b110);
        chk("oe_low_def", 72'(d_mv), 72'b111);
        sig_mask  = ~96'h1;
        gpio_out  = PS ^ 96'h1;
        tick(2);
        chk("oe_unmasked_oe", 72'(o_mv), 72'b111);
        sig_mask  = '1;
        gpio_oe   = '1;

        // Reset during HOLD, then re-arm.
        gpio_out = IDLE;
        pulse_start();
        gpio_out = PS;
        tick(4);
        chk("in_hold_def", {70'd0, d_busy, d_done}, 72'b10);
        #2 HRESETn = 1'b0;
        #1;
        chk("async_rst_def", {d_busy, d_done, d_pass, d_fail, d_timeout, d_mv, 64'(d_cycles)}, 72'd0);
        chk("async_rst_oe",  {o_busy, o_done, o_pass, o_fail, o_timeout, o_mv, 64'(o_cycles)}, 72'd0);
        tick(2);
        HRESETn  = 1'b1;
        gpio_out = IDLE;
        tick(3);
        chk("post_rst_idle_def", {70'd0, d_busy, d_done}, 72'd0);
        pulse_start();
        chk("rearm_cycles_def", {71'(d_cycles), d_busy}, 72'd1);
        tick(1);
        chk("rearm_cycles1_def", 72'(d_cycles), 72'd1);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
